pram_dump_ctrl: RTL

//  Readback counterpart of the PRAM init loader: copies PRAM words 0..DUMP_LEN-1 out to Wishbone RAM.

---
 rtl/pram_dump_ctrl_pkg.sv | 19 +
 rtl/pram_dump_ctrl_wb_tmo_cnt.sv | 42 ++++
 rtl/pram_dump_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pram_dump_ctrl_pkg.sv
// Shared definitions for the PRAM dump controller: default widths, dump length,
// timeout limit and the one-hot FSM state encoding.
package pram_dump_ctrl_pkg;

  localparam int DATA_WL_DEF  = 16;
  localparam int ADR_WL_DEF   = 12;
  localparam int DUMP_LEN_DEF = 80;
  localparam int WB_TMO_DEF   = 255;
  localparam int TMO_WL       = 8;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_READ  = 5'b00010,
    S_CAPT  = 5'b00100,
    S_WRITE = 5'b01000,
    S_NEXT  = 5'b10000
  } dump_state_e;

endpackage

// File: rtl/pram_dump_ctrl_wb_tmo_cnt.sv
// Clear/enable Wishbone timeout counter. term_out flags that the current waiting
// cycle is the LIMIT-th one, so the master can abort without a further cycle.
module wb_tmo_cnt
  import pram_dump_ctrl_pkg::*;
#(
  parameter int WIDTH = TMO_WL,
  parameter int LIMIT = WB_TMO_DEF
) (
  input  logic clk,
  input  logic a_reset,
  input  logic clr_in,
  input  logic en_in,
  output logic term_out
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign term_out = (cnt_q == TERM_VAL);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (en_in && !term_out) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pram_dump_ctrl.sv
// Copies PRAM words 0..DUMP_LEN-1 to Wishbone RAM as a classic single-write master,
// with a per-word ack timeout that aborts the dump and raises a sticky error.
module pram_dump_ctrl
  import pram_dump_ctrl_pkg::*;
#(
  parameter int data_wl  = DATA_WL_DEF,
  parameter int adr_wl   = ADR_WL_DEF,
  parameter int DUMP_LEN = DUMP_LEN_DEF,
  parameter int WB_TMO   = WB_TMO_DEF
) (
  input  logic               clk,
  input  logic               a_reset,
  input  logic               dump_start_in,
  output logic [adr_wl-1:0]  pram_adr_out,
  output logic               pram_re_out,
  input  logic [data_wl-1:0] pram_data_in,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [adr_wl-1:0]  wb_adr_o,
  output logic [data_wl-1:0] wb_dat_o,
  input  logic               wb_ack_i,
  output logic               busy_out,
  output logic               done_out,
  output logic               err_out
);

  localparam logic [adr_wl-1:0] LAST_ADR = adr_wl'(DUMP_LEN - 1);

  dump_state_e        state_q, state_d;
  logic [adr_wl-1:0]  cnt_q, cnt_d;
  logic [adr_wl-1:0]  pram_adr_q, pram_adr_d;
  logic               pram_re_q, pram_re_d;
  logic               wb_req_q, wb_req_d;
  logic [adr_wl-1:0]  wb_adr_q, wb_adr_d;
  logic [data_wl-1:0] wb_dat_q, wb_dat_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               tmo_clr;
  logic               tmo_en;
  logic               tmo_term;

  wb_tmo_cnt #(
    .WIDTH (TMO_WL),
    .LIMIT (WB_TMO)
  ) u_tmo (
    .clk      (clk),
    .a_reset  (a_reset),
    .clr_in   (tmo_clr),
    .en_in    (tmo_en),
    .term_out (tmo_term)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pram_adr_d = pram_adr_q;
    pram_re_d  = 1'b0;
    wb_req_d   = wb_req_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    tmo_clr    = 1'b0;
    tmo_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dump_start_in) begin
          state_d    = S_READ;
          cnt_d      = '0;
          pram_adr_d = '0;
          pram_re_d  = 1'b1;
          busy_d     = 1'b1;
          err_d      = 1'b0;
        end
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        wb_dat_d = pram_data_in;
        wb_adr_d = cnt_q;
        wb_req_d = 1'b1;
        tmo_clr  = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        // An ack on the final allowed cycle still completes the word.
        if (wb_ack_i) begin
          wb_req_d = 1'b0;
          state_d  = S_NEXT;
        end else if (tmo_term) begin
          wb_req_d = 1'b0;
          err_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          tmo_en = 1'b1;
        end
      end
      S_NEXT: begin
        // Terminal compare before increment keeps the counter from wrapping.
        if (cnt_q == LAST_ADR) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          pram_adr_d = cnt_q + 1'b1;
          pram_re_d  = 1'b1;
          state_d    = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pram_adr_q <= '0;
      pram_re_q  <= 1'b0;
      wb_req_q   <= 1'b0;
      wb_adr_q   <= '0;
      wb_dat_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pram_adr_q <= pram_adr_d;
      pram_re_q  <= pram_re_d;
      wb_req_q   <= wb_req_d;
      wb_adr_q   <= wb_adr_d;
      wb_dat_q   <= wb_dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Single-write master: cycle, strobe and write enable always move together.
  assign wb_cyc_o     = wb_req_q;
  assign wb_stb_o     = wb_req_q;
  assign wb_we_o      = wb_req_q;
  assign wb_adr_o     = wb_adr_q;
  assign wb_dat_o     = wb_dat_q;
  assign pram_adr_out = pram_adr_q;
  assign pram_re_out  = pram_re_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign err_out      = err_q;

endmodule
